// File: rtl/mt_err_seq.sv
// MT (TM03) error/attention sequencer: registered error-register strobes, abort/stop handshake with timeout, one ATA per errored op.
// Optional saturating error-event counter on errCNT when MT_ERR_COUNT_EN is defined.
module mt_err_seq #(
  parameter int unsigned TIMEOUT = 1023,
  parameter int unsigned CW      = 10
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mtINIT,
  input  logic        funcGO,
  input  logic        funcDONE,
  input  logic        stopACK,
  input  logic [10:0] evt,
  output logic [10:0] setER,
  output logic        abort,
  output logic        setATA,
  output logic        busy,
  output logic        errSeen,
  output logic [15:0] errCNT
);

  typedef enum logic [2:0] {
    IDLE,
    RUN,
    ABORT,
    WAITSTOP,
    ATTN
  } state_e;

  localparam int unsigned OPI_BIT = 9;

  state_e        state_q, state_d;
  logic [10:0]   setER_q, setER_d;
  logic          errSeen_q, errSeen_d;
  logic [CW-1:0] cnt_q, cnt_d;

  logic clr;
  logic fatal_ev;
  logic reg_ev;
  logic any_ev;
  logic timeout;

  assign clr      = rst | mtINIT;
  assign fatal_ev = |evt[10:6];
  assign reg_ev   = |evt[2:0];
  assign any_ev   = |evt;
  // A stopACK arriving on the timeout cycle suppresses the forced OPI.
  assign timeout  = (state_q == WAITSTOP) && !stopACK && (cnt_q == CW'(TIMEOUT));

  always_ff @(posedge clk) begin
    if (clr) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (reg_ev) begin
          state_d = ATTN;
        end else if (funcGO) begin
          state_d = RUN;
        end
      end
      RUN: begin
        if (fatal_ev) begin
          state_d = ABORT;
        end else if (funcDONE) begin
          state_d = (errSeen_q || any_ev) ? ATTN : IDLE;
        end
      end
      ABORT:    state_d = WAITSTOP;
      WAITSTOP: begin
        if (stopACK || timeout) begin
          state_d = ATTN;
        end
      end
      ATTN:     state_d = IDLE;
      default:  state_d = IDLE;
    endcase
  end

  always_comb begin
    busy   = (state_q == RUN) || (state_q == ABORT) || (state_q == WAITSTOP);
    abort  = (state_q == ABORT);
    setATA = (state_q == ATTN);
  end

  always_comb begin
    setER_d          = evt;
    setER_d[OPI_BIT] = evt[OPI_BIT] | timeout;

    errSeen_d = errSeen_q;
    if ((state_q == IDLE) && funcGO && !reg_ev) begin
      errSeen_d = 1'b0;
    end
    // Events in the start cycle still count against the new function.
    if (any_ev || timeout) begin
      errSeen_d = 1'b1;
    end

    cnt_d = cnt_q;
    if (state_q == ABORT) begin
      cnt_d = '0;
    end else if (state_q == WAITSTOP) begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      setER_q   <= '0;
      errSeen_q <= 1'b0;
      cnt_q     <= '0;
    end else begin
      setER_q   <= setER_d;
      errSeen_q <= errSeen_d;
      cnt_q     <= cnt_d;
    end
  end

  assign setER   = setER_q;
  assign errSeen = errSeen_q;

`ifdef MT_ERR_COUNT_EN
  logic [15:0] ecnt_q;

  always_ff @(posedge clk) begin
    if (clr) begin
      ecnt_q <= '0;
    end else if ((any_ev || timeout) && (ecnt_q != '1)) begin
      ecnt_q <= ecnt_q + 16'd1;
    end
  end

  assign errCNT = ecnt_q;
`else
  assign errCNT = '0;
`endif

endmodule
